// File: rtl/sll_pkg.sv
// ============================================================================
// Module  : sll_pkg
// Purpose : Shared constants, state encoding and stage-weight table for the
//           iterative logical left shifter (sll_iter / sll_stage).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sll_pkg;

  // Datapath width and shift-amount width (SHW = log2(WIDTH))
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  // Width of the stage counter (indexes 0 .. SHW-1)
  localparam int SCW   = $clog2(SHW);

  // Iteration FSM encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Shift distance applied by each stage, listed MSB stage first
  localparam int STAGE_WEIGHT [SHW] = '{16, 8, 4, 2, 1};

  // Shift distance for a stage index; out-of-range indexes shift by 0
  function automatic int stage_weight(input logic [SCW-1:0] st);
    int idx;
    idx = int'(st);
    if (idx < SHW) begin
      return STAGE_WEIGHT[SHW-1-idx];
    end
    return 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sll_stage.sv
// ============================================================================
// Module  : sll_stage
// Purpose : One combinational left-shift step. Shifts the accumulator by the
//           power-of-two weight of the selected stage when enabled and reports
//           whether any 1 bit falls off the top.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sll_stage
  import sll_pkg::*;
(
  input  logic [WIDTH-1:0] i_acc,
  input  logic [SCW-1:0]   i_stage,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_lost
);

  int               w_dist;
  logic [WIDTH-1:0] w_mask;

  // Shift by the stage weight; the mask covers exactly the bits pushed out
  always_comb begin
    w_dist = stage_weight(i_stage);
    w_mask = ~({WIDTH{1'b1}} >> w_dist);
    o_acc  = i_en ? (i_acc << w_dist) : i_acc;
    o_lost = i_en & (|(i_acc & w_mask));
  end

endmodule

`default_nettype wire

// File: rtl/sll_iter.sv
// ============================================================================
// Module  : sll_iter
// Purpose : Multi-cycle logical left shifter. One shift-amount bit is consumed
//           per cycle, MSB first (weights 16,8,4,2,1), with a start/ready/done
//           handshake and a sticky flag for any 1 bit shifted out.
//           Optional macro SLL_ITER_EARLY_EXIT_EN: finish as soon as no set
//           shift-amount bits remain below the current stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sll_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  import sll_pkg::state_t;
  import sll_pkg::IDLE;
  import sll_pkg::SHIFT;
  import sll_pkg::SCW;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_amt;
  logic [SCW-1:0]   r_stage;
  logic             r_sticky;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_done;

  logic [WIDTH-1:0] w_shifted;
  logic             w_lost;
  logic             w_en;
  logic             w_last;
  logic             w_accept;

  // Does the current stage apply its shift
  always_comb begin
    w_en = r_amt[r_stage];
  end

  sll_stage u_stage (
    .i_acc   (r_acc),
    .i_stage (r_stage),
    .i_en    (w_en),
    .o_acc   (w_shifted),
    .o_lost  (w_lost)
  );

`ifdef SLL_ITER_EARLY_EXIT_EN
  logic [SHW-1:0] w_below;

  // Finish once every shift-amount bit below the current stage is clear
  always_comb begin
    w_below = (SHW'(1) << r_stage) - SHW'(1);
    w_last  = ~|(r_amt & w_below);
  end
`else
  // Fixed latency: finish after the weight-1 stage
  always_comb begin
    w_last = (r_stage == '0);
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = SHIFT;
      SHIFT:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode: ready whenever idle
  always_comb begin
    ready    = (r_state == IDLE);
    w_accept = ready & start;
  end

  // Datapath: capture operands, iterate stages, publish result with done pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_amt    <= '0;
      r_stage  <= '0;
      r_sticky <= 1'b0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc    <= in;
        r_amt    <= shamt;
        r_stage  <= SCW'(SHW - 1);
        r_sticky <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_acc    <= w_shifted;
        r_sticky <= r_sticky | w_lost;
        if (w_last) begin
          r_out  <= w_shifted;
          r_ovf  <= r_sticky | w_lost;
          r_done <= 1'b1;
        end else begin
          r_stage <= r_stage - SCW'(1);
        end
      end
    end
  end

  assign done = r_done;
  assign out  = r_out;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sll_iter.sv
// ============================================================================
// Module  : tb_sll_iter
// Purpose : Self-checking bench for sll_iter with a scoreboard of expected
//           results (out, ovf, latency) pushed at stimulus time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sll_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] din;
  logic [4:0]  sh;
  logic        ready;
  logic        done;
  logic [31:0] dout;
  logic        ovf;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  sll_iter dut (
    .clock   (clk),
    .reset_n (rst_n),
    .start   (start),
    .in      (din),
    .shamt   (sh),
    .ready   (ready),
    .done    (done),
    .out     (dout),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_lat(input logic [4:0] s);
`ifdef SLL_ITER_EARLY_EXIT_EN
    if (s == 5'd0) return 1;
    for (int k = 0; k < 5; k++) begin
      if (s[k]) return 5 - k;
    end
    return 1;
`else
    return 5;
`endif
  endfunction

  function automatic exp_t model(input logic [31:0] d, input logic [4:0] s);
    exp_t e;
    logic [31:0] hi;
    e.out = d << s;
    hi    = (s == 5'd0) ? 32'd0 : (d >> (32 - int'(s)));
    e.ovf = |hi;
    e.lat = model_lat(s);
    return e;
  endfunction

  // Issue one operation, wait for done, measure latency and pulse width
  task automatic drive_op(input logic [31:0] d, input logic [4:0] s,
                          output int lat, output logic narrow);
    sb.push_back(model(d, s));
    @(negedge clk);
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    start = 1'b1;
    din   = d;
    sh    = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = $urandom;
    sh    = 5'($urandom_range(0, 31));
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    narrow = (done === 1'b0);
  endtask

  task automatic test_reset();
    exp_t e;
    int   lat;
    logic narrow;
    total++;
    if ({ready, done, dout, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got ready=%b done=%b out=%h ovf=%b need 1 0 0 0",
               ready, done, dout, ovf);
    end
    drive_op(32'h0000_0001, 5'd3, lat, narrow);
    e = sb.pop_front();
    total++;
    if (dout !== e.out) begin
      bad++;
      $display("FAIL pre_reset_out: got %h need %h", dout, e.out);
    end
    // abandon an operation mid-flight
    @(negedge clk);
    start = 1'b1; din = 32'hFFFF_FFFF; sh = 5'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ready, done, dout, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got ready=%b done=%b out=%h ovf=%b need 1 0 0 0",
               ready, done, dout, ovf);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL no_spurious_done: cycle %0d got done=%b need 0", i, done);
      end
    end
    total++;
    if ({ready, dout, ovf} !== {1'b1, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_idle: got ready=%b out=%h ovf=%b need 1 0 0", ready, dout, ovf);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ds [4] = '{32'h0000_0001, 32'hF000_000F, 32'hF000_000F, 32'h1234_5678};
    logic [4:0]  ss [4] = '{5'd31, 5'd4, 5'd0, 5'd16};
    exp_t e;
    int   lat;
    logic narrow;
    for (int i = 0; i < 4; i++) begin
      drive_op(ds[i], ss[i], lat, narrow);
      e = sb.pop_front();
      total++;
      if (dout !== e.out || ovf !== e.ovf) begin
        bad++;
        $display("FAIL directed_%0d: got out=%h ovf=%b need out=%h ovf=%b",
                 i, dout, ovf, e.out, e.ovf);
      end
      total++;
      if (lat !== e.lat) begin
        bad++;
        $display("FAIL directed_lat_%0d: got %0d need %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_handshake();
    exp_t e;
    int   seen = 0;
    sb.push_back(model(32'h8000_0003, 5'd3));
    @(negedge clk);
    start = 1'b1; din = 32'h8000_0003; sh = 5'd3;
    @(posedge clk);                  // E0
    #1 start = 1'b0;
    @(posedge clk);                  // E1
    #1 start = 1'b1; din = 32'h0000_00AA; sh = 5'd0;
    @(posedge clk);                  // E2: must be ignored
    #1 start = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (done !== (k == 5)) begin
        bad++;
        $display("FAIL hs_done_E%0d: got %b need %b", k, done, (k == 5));
      end
      if (done === 1'b1) begin
        seen++;
        e = sb.pop_front();
        total++;
        if (dout !== e.out || ovf !== e.ovf) begin
          bad++;
          $display("FAIL hs_result: got out=%h ovf=%b need out=%h ovf=%b",
                   dout, ovf, e.out, e.ovf);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL hs_done_count: got %0d need 1", seen);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back(model(32'hC000_1234, 5'd1));
    sb.push_back(model(32'h1357_9BDF, 5'd1));
    @(negedge clk);
    start = 1'b1; din = 32'hC000_1234; sh = 5'd1;
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) din = 32'h1357_9BDF;
      if (k == 6) start = 1'b0;
      @(negedge clk);
      if (k >= 1) begin
        total++;
        if (done !== (k == 5 || k == 11)) begin
          bad++;
          $display("FAIL b2b_done_E%0d: got %b need %b", k, done, (k == 5 || k == 11));
        end
        if (done === 1'b1 && sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (dout !== e.out || ovf !== e.ovf) begin
            bad++;
            $display("FAIL b2b_result_E%0d: got out=%h ovf=%b need out=%h ovf=%b",
                     k, dout, ovf, e.out, e.ovf);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_leftover: got %0d pending need 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat;
    logic        narrow;
    logic [31:0] d;
    logic [4:0]  s;
    for (int n = 0; n < 1000; n++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      drive_op(d, s, lat, narrow);
      e = sb.pop_front();
      total++;
      if (dout !== e.out || ovf !== e.ovf) begin
        bad++;
        $display("FAIL rand_%0d in=%h sh=%0d: got out=%h ovf=%b need out=%h ovf=%b",
                 n, d, s, dout, ovf, e.out, e.ovf);
      end
      total++;
      if (lat !== e.lat) begin
        bad++;
        $display("FAIL rand_lat_%0d sh=%0d: got %0d need %0d", n, s, lat, e.lat);
      end
      total++;
      if (!narrow) begin
        bad++;
        $display("FAIL rand_done_width_%0d: got done high 2 cycles need 1", n);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    sh    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
